// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared opcode, FSM-state and frame types for the command controller
package cmd_pkg;

   typedef enum logic [3:0] {
      OP_WRITE_CELL = 4'h1,
      OP_WRITE_INC  = 4'h2,
      OP_SET_PTR    = 4'h3,
      OP_SET_SCORE  = 4'h4,
      OP_SET_STATE  = 4'h5,
      OP_CLEAR      = 4'h6
   } opcode_e;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_EXEC  = 2'd1,
      FSM_CLEAR = 2'd2
   } fsm_e;

   typedef struct packed {
      logic [7:0] command;
      logic [7:0] databyte1;
      logic [7:0] databyte2;
   } frame_t;

   function automatic logic [15:0] payload_of(input frame_t f);
      return {f.databyte1, f.databyte2};
   endfunction

endpackage

// File: rtl/cmd_ctrl_frame_fifo.sv
// rtl/cmd_ctrl_frame_fifo.sv - frame FIFO with sticky overflow on push-when-full
module frame_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = cmd_pkg::frame_t
) (
   input  logic clk,
   input  logic resetB,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output T     head_o,
   output logic full_o,
   output logic empty_o,
   output logic overflow_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   T              mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [PW:0]   cnt_q;
   logic          ovf_q;
   logic          do_push, do_pop;

   // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
   assign full_o     = (cnt_q == FULL_CNT);
   assign empty_o    = (cnt_q == '0);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign head_o     = mem_q[rd_q];
   assign overflow_o = ovf_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
         if (push_i && full_o) ovf_q <= 1'b1;
      end
   end

endmodule

// File: rtl/cmd_ctrl.sv
// rtl/cmd_ctrl.sv - executes buffered 3-byte frames against frame memory, score and game state
module cmd_ctrl
   import cmd_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int CELL_W     = 4,
   parameter int SCORE_W    = 10,
   parameter int STATE_W    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               resetB,
   input  logic               frame_valid,
   input  logic [7:0]         command,
   input  logic [7:0]         databyte1,
   input  logic [7:0]         databyte2,
   output logic               we,
   output logic [ADDR_W-1:0]  waddr,
   output logic [CELL_W-1:0]  wdata,
   input  logic               mem_ready,
   output logic [SCORE_W-1:0] score,
   output logic [STATE_W-1:0] state,
   output logic               busy,
   output logic               overflow,
   output logic [7:0]         err_count
);

   localparam logic [1:0]  ST_IDLE   = FSM_IDLE;
   localparam logic [1:0]  ST_EXEC   = FSM_EXEC;
   localparam logic [1:0]  ST_CLEAR  = FSM_CLEAR;
   localparam logic [16:0] SCORE_MAX = 17'((17'd1 << SCORE_W) - 17'd1);

   frame_t push_frame, head;
   logic   fifo_pop, fifo_full, fifo_empty;

   logic [1:0]         fsm_q, fsm_d;
   frame_t             cmd_q, cmd_d;
   logic [ADDR_W-1:0]  wptr_q, wptr_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic [CELL_W-1:0]  wdata_q, wdata_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [STATE_W-1:0] gstate_q, gstate_d;
   logic [7:0]         err_q, err_d;

   logic [3:0]  opcode;
   logic [15:0] payload;

   assign push_frame = {command, databyte1, databyte2};
   assign opcode     = cmd_q.command[7:4];
   assign payload    = payload_of(cmd_q);

   frame_fifo #(.DEPTH(FIFO_DEPTH), .T(frame_t)) u_fifo (
      .clk        (clk),
      .resetB     (resetB),
      .push_i     (frame_valid),
      .push_data_i(push_frame),
      .pop_i      (fifo_pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .overflow_o (overflow)
   );

   always_comb begin
      fsm_d    = fsm_q;
      cmd_d    = cmd_q;
      wptr_d   = wptr_q;
      we_d     = we_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      score_d  = score_q;
      gstate_d = gstate_q;
      err_d    = err_q;
      fifo_pop = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = head;
               fsm_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // A raised we marks the second phase of a write: wait for acceptance.
            if (we_q) begin
               if (mem_ready) begin
                  we_d  = 1'b0;
                  fsm_d = ST_IDLE;
                  if (opcode == OP_WRITE_INC) wptr_d = wptr_q + 1'b1;
               end
            end else begin
               case (opcode)
                  OP_WRITE_CELL: begin
                     we_d    = 1'b1;
                     waddr_d = payload[ADDR_W-1:0];
                     wdata_d = cmd_q.command[CELL_W-1:0];
                  end
                  OP_WRITE_INC: begin
                     we_d    = 1'b1;
                     waddr_d = wptr_q;
                     wdata_d = cmd_q.command[CELL_W-1:0];
                  end
                  OP_SET_PTR: begin
                     wptr_d = payload[ADDR_W-1:0];
                     fsm_d  = ST_IDLE;
                  end
                  OP_SET_SCORE: begin
                     score_d = ({1'b0, payload} > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                                              : payload[SCORE_W-1:0];
                     fsm_d   = ST_IDLE;
                  end
                  OP_SET_STATE: begin
                     gstate_d = payload[STATE_W-1:0];
                     fsm_d    = ST_IDLE;
                  end
                  OP_CLEAR: begin
                     we_d    = 1'b1;
                     waddr_d = '0;
                     wdata_d = cmd_q.command[CELL_W-1:0];
                     fsm_d   = ST_CLEAR;
                  end
                  default: begin
                     if (err_q != 8'hFF) err_d = err_q + 8'd1;
                     fsm_d = ST_IDLE;
                  end
               endcase
            end
         end
         ST_CLEAR: begin
            if (we_q && mem_ready) begin
               if (waddr_q == '1) begin
                  we_d   = 1'b0;
                  wptr_d = '0;
                  fsm_d  = ST_IDLE;
               end else begin
                  waddr_d = waddr_q + 1'b1;
               end
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         fsm_q    <= ST_IDLE;
         cmd_q    <= '0;
         wptr_q   <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         score_q  <= '0;
         gstate_q <= '0;
         err_q    <= '0;
      end else begin
         fsm_q    <= fsm_d;
         cmd_q    <= cmd_d;
         wptr_q   <= wptr_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         score_q  <= score_d;
         gstate_q <= gstate_d;
         err_q    <= err_d;
      end
   end

   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign score     = score_q;
   assign state     = gstate_q;
   assign err_count = err_q;
   assign busy      = (fsm_q != ST_IDLE) || !fifo_empty;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: doc/cmd_ctrl.md
Name: cmd_ctrl

Overview:
- Command controller between the SPI frame receiver and the frame-buffer memory, score register and game-state register.
- Accepts 3-byte frames (command, databyte1, databyte2) already synchronised into the clk domain and buffers them in a FIFO.
- Decodes and executes frames one at a time: cell write, auto-increment write, score load, state load, full memory clear.
- Parametrised in address/cell/score/state widths and FIFO depth; adds overflow and error reporting plus a write handshake with memory.

Parameters:
ADDR_W, 10, memory address width; memory holds 2**ADDR_W cells
CELL_W, 4, cell data width; must be <= 4 (taken from command[3:0])
SCORE_W, 10, score register width (<= 16)
STATE_W, 16, game-state register width (<= 16)
FIFO_DEPTH, 4, frame FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
resetB  in  1  asynchronous active-low reset
frame_valid  in  1  one-cycle pulse: command/databyte1/databyte2 hold a complete frame
command  in  8  opcode [7:4], cell value [3:0]
databyte1  in  8  payload high byte
databyte2  in  8  payload low byte
we  out  1  memory write request
waddr  out  ADDR_W  memory write address
wdata  out  CELL_W  memory write data
mem_ready  in  1  memory accepts the write on any cycle where we && mem_ready
score  out  SCORE_W  current score
state  out  STATE_W  current game state
busy  out  1  FSM not IDLE, or FIFO not empty
overflow  out  1  sticky; a frame was dropped
err_count  out  8  saturating count of illegal opcodes

Behaviour:
- Reset (resetB low, asynchronous):
  - All outputs 0, FIFO empty, FSM IDLE, write pointer wptr = 0.
  - Reset mid-CLEAR or mid-write aborts the operation immediately; there is no resume.
- FIFO:
  - Push on frame_valid, storing {command, databyte1, databyte2}.
  - If the FIFO is full at the push cycle, the frame is dropped and overflow is set. Fullness is judged before any same-cycle pop.
  - overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH.
- payload = {databyte1, databyte2}; truncation takes the low bits.
- FSM states: IDLE, EXEC, CLEAR.
  - IDLE:
    - FIFO not empty: pop the head into a command register and go to EXEC.
    - Latency: frame pushed at cycle N, popped at N+1, EXEC at N+2.
  - EXEC, by opcode:
    - 0x1 WRITE_CELL: waddr = payload[ADDR_W-1:0], wdata = command[CELL_W-1:0], we = 1. Hold until mem_ready, then go to IDLE with we = 0 on the next cycle.
    - 0x2 WRITE_INC: same handshake, using waddr = wptr. On acceptance wptr increments, wrapping from 2**ADDR_W-1 to 0. Payload is ignored.
    - 0x3 SET_PTR: wptr = payload[ADDR_W-1:0]; one cycle; go to IDLE.
    - 0x4 SET_SCORE: score = min(payload, 2**SCORE_W-1), i.e. saturate, never truncate. Updated at the end of the EXEC cycle; go to IDLE.
    - 0x5 SET_STATE: state = payload[STATE_W-1:0]; one cycle; go to IDLE.
    - 0x6 CLEAR: go to CLEAR with waddr = 0 and wdata = command[CELL_W-1:0].
    - Any other opcode (including 0x0 and 0x7–0xF): err_count increments, saturating at 255; nothing else changes; go to IDLE.
  - CLEAR:
    - we = 1; on each accepted write waddr increments.
    - When the write at address 2**ADDR_W-1 is accepted, go to IDLE and set wptr = 0.
    - Frames arriving during CLEAR queue in the FIFO; they are never executed concurrently.
- Handshake rules:
  - we, waddr and wdata are registered and stable while we is high and mem_ready is low.
  - we never deasserts without acceptance except on reset.
- Simultaneous events: a push and a pop in the same cycle on a non-full FIFO leave the count unchanged.

Decomposition:
- Package cmd_pkg:
  - opcode enum (OP_WRITE_CELL=1, OP_WRITE_INC=2, OP_SET_PTR=3, OP_SET_SCORE=4, OP_SET_STATE=5, OP_CLEAR=6)
  - FSM state enum
  - frame struct {command, databyte1, databyte2}
- Sub-module frame_fifo, parametrised by FIFO_DEPTH and the frame struct. It provides push, pop, full, empty, head and overflow.

Test Plan:
- frame 0x13,0x01,0x2C, mem_ready=1 -> we high for exactly 1 cycle, 2 cycles after pop; waddr=0x12C, wdata=0x3.
- SET_SCORE payload 0x0400 (ADDR_W/SCORE_W=10) -> score=1023; payload 0x0064 -> score=100, visible at N+3.
- SET_PTR 0x3FF, then two WRITE_INC 0x27 -> writes to 0x3FF then 0x000, wdata=7; mem_ready low for 3 cycles holds we/waddr steady.
- CLEAR 0x65 with mem_ready toggling 50% -> exactly 1024 accepted writes, addresses 0..1023 in order, wdata=5, busy falls after the last one.
- 6 frame_valid pulses during CLEAR (FIFO_DEPTH=4) -> first 4 execute in order afterward, last 2 dropped, overflow=1 until reset.
- opcode 0xF0 ×300 -> err_count=255; assert resetB low mid-CLEAR -> we=0, all outputs 0 at once; next frame executes normally.
